io_output_bank: RTL and testbench

Parametrised memory-mapped output peripheral bank for the single-cycle RISC-V core's LSU I/O window (0x7000–0x704F). It holds the red/green LED, seven-segment and LCD registers and accepts byte/half/word stores merged into the addressed register. Every register reads back on the load path. An LCD register write launches a timed setup/enable/hold strobe sequence with busy and overrun status.

---
 rtl/io_output_bank.sv | 200 ++++++++++++++++++++
 tb/tb_io_output_bank.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/io_output_bank.sv
`timescale 1ns/1ps
// Memory-mapped output bank: LED, seven-segment and LCD registers with byte/half/word
// store merge, combinational readback and a timed LCD setup/enable/hold strobe sequencer.
module io_output_bank #(
  parameter int NUM_HEX   = 8,
  parameter int LEDR_W    = 32,
  parameter int LEDG_W    = 32,
  parameter int LCD_SETUP = 2,
  parameter int LCD_PULSE = 4,
  parameter int LCD_HOLD  = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_en,
  input  logic                 i_st_en,
  input  logic [2:0]           i_st_size,
  input  logic [15:0]          i_addr,
  input  logic [31:0]          i_st_data,
  output logic [31:0]          o_ld_data,
  output logic [LEDR_W-1:0]    o_ledr,
  output logic [LEDG_W-1:0]    o_ledg,
  output logic [7*NUM_HEX-1:0] o_hex,
  output logic [31:0]          o_lcd,
  output logic                 o_lcd_en,
  output logic                 o_lcd_busy
);

  // state   | meaning
  // S_IDLE  | no LCD transfer in flight
  // S_SETUP | data stable, enable low, LCD_SETUP cycles
  // S_PULSE | enable high, LCD_PULSE cycles
  // S_HOLD  | enable low, data held, LCD_HOLD cycles
  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_PULSE, S_HOLD} lcd_state_t;

  localparam int CNT_W = 16;

  lcd_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lcd_en_d, lcd_busy_d;

  logic [LEDR_W-1:0] ledr_q;
  logic [LEDG_W-1:0] ledg_q;
  logic [6:0]        hex_q [NUM_HEX];
  logic [31:0]       lcd_q;
  logic              ovr_q;

  logic        sel_ledr, sel_ledg, sel_hex, sel_lcd, sel_stat;
  logic [3:0]  be;
  logic [31:0] wdata, wmask;
  logic        wr, lcd_wr, lcd_free, lcd_start;
  logic [31:0] ledr_rd, ledg_rd, hex_rd, ledr_mg, ledg_mg, lcd_mg;
  logic [127:0] hex_flat;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [31:0] m);
    return (old & ~m) | (d & m);
  endfunction

  assign sel_ledr = (i_addr[15:4] == 12'h700);
  assign sel_ledg = (i_addr[15:4] == 12'h701);
  assign sel_hex  = (i_addr[15:4] == 12'h702);
  assign sel_lcd  = (i_addr[15:4] == 12'h703);
  assign sel_stat = (i_addr[15:4] == 12'h704);

  // Lane enables; misaligned or unknown-size stores leave be at zero.
  always_comb begin
    be    = '0;
    wdata = i_st_data;
    if (i_en && i_st_en) begin
      case (i_st_size)
        3'd0: begin
          be    = 4'b0001 << i_addr[1:0];
          wdata = {4{i_st_data[7:0]}};
        end
        3'd1: begin
          if (!i_addr[0]) be = i_addr[1] ? 4'b1100 : 4'b0011;
          wdata = {2{i_st_data[15:0]}};
        end
        3'd2: if (i_addr[1:0] == 2'b00) be = 4'b1111;
        default: be = '0;
      endcase
    end
    for (int i = 0; i < 4; i++) wmask[8*i +: 8] = {8{be[i]}};
  end

  assign wr = |be;

  always_comb begin
    hex_flat = '0;
    o_hex    = '0;
    for (int d = 0; d < NUM_HEX; d++) begin
      hex_flat[8*d +: 8] = {1'b0, hex_q[d]};
      o_hex[7*d +: 7]    = hex_q[d];
    end
  end

  assign ledr_rd = 32'(ledr_q);
  assign ledg_rd = 32'(ledg_q);
  assign hex_rd  = hex_flat[{i_addr[3:2], 5'b0} +: 32];
  assign ledr_mg = merge(ledr_rd, wdata, wmask);
  assign ledg_mg = merge(ledg_rd, wdata, wmask);
  assign lcd_mg  = merge(lcd_q, wdata, wmask);

  // The last HOLD cycle counts as idle so a write on the busy-fall edge restarts cleanly.
  assign lcd_free  = (state_q == S_IDLE) || (state_q == S_HOLD && cnt_q == '0);
  assign lcd_wr    = wr && sel_lcd;
  assign lcd_start = lcd_wr && lcd_free;

  always_comb begin
    case (i_addr[15:4])
      12'h700: o_ld_data = ledr_rd;
      12'h701: o_ld_data = ledg_rd;
      12'h702: o_ld_data = hex_rd;
      12'h703: o_ld_data = lcd_q;
      12'h704: o_ld_data = {30'b0, ovr_q, o_lcd_busy};
      default: o_ld_data = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ledr_q <= '0;
      ledg_q <= '0;
      lcd_q  <= '0;
      ovr_q  <= 1'b0;
      for (int d = 0; d < NUM_HEX; d++) hex_q[d] <= '0;
    end else begin
      if (wr && sel_ledr) ledr_q <= ledr_mg[LEDR_W-1:0];
      if (wr && sel_ledg) ledg_q <= ledg_mg[LEDG_W-1:0];
      for (int d = 0; d < NUM_HEX; d++) begin
        if (sel_hex && be[d%4] && i_addr[3:2] == 2'(d/4))
          hex_q[d] <= wdata[8*(d%4) +: 7];
      end
      if (lcd_start) lcd_q <= lcd_mg;
      if (lcd_wr && !lcd_free) ovr_q <= 1'b1;
      else if (wr && sel_stat && be[0] && wdata[1]) ovr_q <= 1'b0;
    end
  end

  assign o_ledr = ledr_q;
  assign o_ledg = ledg_q;
  assign o_lcd  = lcd_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      o_lcd_en   <= 1'b0;
      o_lcd_busy <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      o_lcd_en   <= lcd_en_d;
      o_lcd_busy <= lcd_busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (lcd_start) begin
          state_d = S_SETUP;
          cnt_d   = CNT_W'(LCD_SETUP - 1);
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          state_d = S_PULSE;
          cnt_d   = CNT_W'(LCD_PULSE - 1);
        end else cnt_d = cnt_q - 1'b1;
      end
      S_PULSE: begin
        if (cnt_q == '0) begin
          state_d = S_HOLD;
          cnt_d   = CNT_W'(LCD_HOLD - 1);
        end else cnt_d = cnt_q - 1'b1;
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          if (lcd_start) begin
            state_d = S_SETUP;
            cnt_d   = CNT_W'(LCD_SETUP - 1);
          end else state_d = S_IDLE;
        end else cnt_d = cnt_q - 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    lcd_en_d   = (state_d == S_PULSE);
    lcd_busy_d = (state_d != S_IDLE);
  end

endmodule

// File: tb/tb_io_output_bank.sv
`timescale 1ns/1ps
// Directed bench for io_output_bank: vector table for store merge/readback,
// hand sequences for reset, LCD timing, overrun and back-to-back writes.
module tb_io_output_bank;

  logic        i_clk, i_rst_n, i_en, i_st_en;
  logic [2:0]  i_st_size;
  logic [15:0] i_addr;
  logic [31:0] i_st_data, o_ld_data, o_ledr, o_ledg, o_lcd;
  logic [55:0] o_hex;
  logic        o_lcd_en, o_lcd_busy;

  int n_pass = 0;
  int n_total = 0;

  io_output_bank dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en), .i_st_en(i_st_en),
    .i_st_size(i_st_size), .i_addr(i_addr), .i_st_data(i_st_data),
    .o_ld_data(o_ld_data), .o_ledr(o_ledr), .o_ledg(o_ledg), .o_hex(o_hex),
    .o_lcd(o_lcd), .o_lcd_en(o_lcd_en), .o_lcd_busy(o_lcd_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [2:0]  size;
    logic [15:0] addr;
    logic [31:0] data;
    logic [15:0] rd_addr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Called at the falling-edge phase; returns one falling edge later.
  task automatic do_store(input logic [2:0] size, input logic [15:0] addr, input logic [31:0] data);
    i_st_en   = 1'b1;
    i_st_size = size;
    i_addr    = addr;
    i_st_data = data;
    @(negedge i_clk);
    i_st_en = 1'b0;
  endtask

  task automatic rd(input logic [15:0] addr, output logic [31:0] val);
    i_addr = addr;
    #1;
    val = o_ld_data;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 20 && o_lcd_busy; n++) @(negedge i_clk);
    chk("lcd_idle_wait", o_lcd_busy, 0);
  endtask

  task automatic lcd_seq(input logic [31:0] d);
    do_store(3'd2, 16'h7030, d);
    for (int k = 1; k <= 9; k++) begin
      chk("lcd_busy", o_lcd_busy, (k <= 8));
      chk("lcd_en", o_lcd_en, (k >= 3 && k <= 6));
      chk("lcd_data", o_lcd, d);
      if (k < 9) @(negedge i_clk);
    end
  endtask

  logic [31:0] v;

  initial begin
    vecs[0]  = '{3'd2, 16'h7000, 32'hDEADBEEF, 16'h7000, 32'hDEADBEEF};
    vecs[1]  = '{3'd2, 16'h7010, 32'h12345678, 16'h7010, 32'h12345678};
    vecs[2]  = '{3'd2, 16'h7000, 32'hFFFFFFFF, 16'h7000, 32'hFFFFFFFF};
    vecs[3]  = '{3'd0, 16'h7002, 32'h00000000, 16'h7000, 32'hFF00FFFF};
    vecs[4]  = '{3'd1, 16'h7000, 32'h0000A5A5, 16'h7000, 32'hFF00A5A5};
    vecs[5]  = '{3'd1, 16'h7003, 32'h00001234, 16'h7000, 32'hFF00A5A5};
    vecs[6]  = '{3'd2, 16'h7001, 32'h00000000, 16'h7000, 32'hFF00A5A5};
    vecs[7]  = '{3'd2, 16'h7020, 32'h7F7F7F7F, 16'h7020, 32'h7F7F7F7F};
    vecs[8]  = '{3'd2, 16'h7024, 32'h01020304, 16'h7024, 32'h01020304};
    vecs[9]  = '{3'd2, 16'h7028, 32'hFFFFFFFF, 16'h7028, 32'h00000000};
    vecs[10] = '{3'd2, 16'h7020, 32'hFFFFFFFF, 16'h7020, 32'h7F7F7F7F};
    vecs[11] = '{3'd0, 16'h7013, 32'h000000AB, 16'h7010, 32'hAB345678};
    vecs[12] = '{3'd3, 16'h7010, 32'h00000000, 16'h7010, 32'hAB345678};
    vecs[13] = '{3'd1, 16'h7012, 32'h0000BEEF, 16'h7010, 32'hBEEF5678};
    vecs[14] = '{3'd2, 16'h7050, 32'hFFFFFFFF, 16'h7050, 32'h00000000};

    i_rst_n = 1'b0; i_en = 1'b1; i_st_en = 1'b0;
    i_st_size = '0; i_addr = '0; i_st_data = '0;
    repeat (2) @(negedge i_clk);
    chk("rst_ledr", o_ledr, 0);
    chk("rst_hex", o_hex, 0);
    chk("rst_lcd_busy", o_lcd_busy, 0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    for (int i = 0; i < 15; i++) begin
      do_store(vecs[i].size, vecs[i].addr, vecs[i].data);
      rd(vecs[i].rd_addr, v);
      chk($sformatf("vec%0d_rd", i), v, vecs[i].exp);
    end
    chk("hex_digits", o_hex, {7'd1, 7'd2, 7'd3, 7'd4, 28'hFFFFFFF});
    chk("ledr_merge", o_ledr, 32'hFF00A5A5);

    @(negedge i_clk);
    do_store(3'd2, 16'h7000, 32'hDEADBEEF);
    do_store(3'd2, 16'h7010, 32'h12345678);
    chk("ledr_word", o_ledr, 32'hDEADBEEF);
    chk("ledg_word", o_ledg, 32'h12345678);
    #2 i_rst_n = 1'b0;
    #1;
    chk("async_rst_ledr", o_ledr, 0);
    chk("async_rst_ledg", o_ledg, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    lcd_seq(32'h41);

    do_store(3'd2, 16'h7030, 32'h41);
    repeat (2) @(negedge i_clk);
    do_store(3'd0, 16'h7030, 32'h42);
    chk("ovr_lcd_kept", o_lcd, 32'h41);
    rd(16'h7040, v);
    chk("ovr_status_busy", v, 32'h3);
    wait_idle();
    rd(16'h7040, v);
    chk("ovr_sticky", v, 32'h2);
    @(negedge i_clk);
    do_store(3'd2, 16'h7040, 32'h2);
    rd(16'h7040, v);
    chk("ovr_w1c", v, 32'h0);

    @(negedge i_clk);
    do_store(3'd2, 16'h7030, 32'h55);
    repeat (7) @(negedge i_clk);
    chk("b2b_busy_last", o_lcd_busy, 1);
    do_store(3'd2, 16'h7030, 32'h66);
    chk("b2b_busy", o_lcd_busy, 1);
    chk("b2b_data", o_lcd, 32'h66);
    rd(16'h7040, v);
    chk("b2b_no_ovr", v, 32'h1);
    repeat (2) @(negedge i_clk);
    chk("b2b_en", o_lcd_en, 1);
    wait_idle();

    @(negedge i_clk);
    do_store(3'd2, 16'h7030, 32'h77);
    repeat (2) @(negedge i_clk);
    chk("mid_en_high", o_lcd_en, 1);
    #2 i_rst_n = 1'b0;
    #1;
    chk("mid_rst_en", o_lcd_en, 0);
    chk("mid_rst_busy", o_lcd_busy, 0);
    chk("mid_rst_lcd", o_lcd, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    lcd_seq(32'h12);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
